// File: rtl/palindrome_pkg.sv
// Shared types and sizing helpers for the serial palindrome frame generator.
package palindrome_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned N_DEFAULT = 5;

  // Seed holds the first half of the frame plus the centre bit.
  function automatic int unsigned seed_width(input int unsigned n);
    return (n + 1) / 2;
  endfunction

  function automatic int unsigned index_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/palindrome_frame_counter.sv
// Bit-index counter for one serial frame: exposes the next index and a last-bit flag.
module palindrome_frame_counter
  import palindrome_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned KW = index_width(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_run,
  output logic [KW-1:0] o_k_next,
  output logic          o_last
);

  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  logic [KW-1:0] r_k;

  assign o_last = i_run && (r_k == K_LAST);

  // Index restarts at 0 on a capture, after the last bit, and while idle.
  always_comb begin
    o_k_next = '0;
    if (!i_load && i_run && !o_last) begin
      o_k_next = r_k + KW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_k <= '0;
    end else begin
      r_k <= o_k_next;
    end
  end

endmodule

// File: rtl/palindrome_sequence_generator.sv
// Emits an N-bit palindrome serially from an H-bit seed, with back-to-back frame support.
module palindrome_sequence_generator
  import palindrome_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic [seed_width(N)-1:0]   SEED,
  output logic                       OUT,
  output logic                       VALID,
  output logic                       BUSY,
  output logic                       DONE
);

  localparam int unsigned   H      = seed_width(N);
  localparam int unsigned   KW     = index_width(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [H-1:0]  r_s;
  logic [H-1:0]  w_s_next;
  logic          w_capture;
  logic          w_run;
  logic          w_last;
  logic [KW-1:0] w_k_next;
  logic [N-1:0]  w_frame;
  logic          r_out;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;

  assign w_run = (r_state == SEND);

  palindrome_frame_counter #(
    .N  (N),
    .KW (KW)
  ) u_frame_counter (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_load   (w_capture),
    .i_run    (w_run),
    .o_k_next (w_k_next),
    .o_last   (w_last)
  );

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (START) begin
          w_capture    = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (w_last) begin
          if (START) begin
            w_capture = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_s_next = w_capture ? SEED : r_s;

  // Mirrored view of the next seed: frame bit g comes from seed bit SRC.
  for (genvar g = 0; g < N; g++) begin : g_frame
    localparam int unsigned SRC = (g < H) ? (H - 1 - g) : (g - H + 1);
    assign w_frame[g] = w_s_next[SRC];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Outputs are registered from next-state values so bit k appears while the counter holds k.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s     <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_s     <= w_s_next;
      r_out   <= (w_state_next == SEND) && w_frame[w_k_next];
      r_valid <= (w_state_next == SEND);
      r_busy  <= (w_state_next == SEND);
      r_done  <= (w_state_next == SEND) && (w_k_next == K_LAST);
    end
  end

  assign OUT   = r_out;
  assign VALID = r_valid;
  assign BUSY  = r_busy;
  assign DONE  = r_done;

endmodule

// File: tb/tb_palindrome_sequence_generator.sv
// Directed bench for the palindrome generator at N=5, N=7 and N=3.
module tb_palindrome_sequence_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st5, st7, st3;
  logic [2:0] sd5;
  logic [3:0] sd7;
  logic [1:0] sd3;
  logic       o5, v5, b5, d5;
  logic       o7, v7, b7, d7;
  logic       o3, v3, b3, d3;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [4:0]  hist = '0;
  logic [2:0]  cur, nxt;
  logic [6:0]  e7;
  logic [2:0]  tab3 [4] = '{3'b000, 3'b010, 3'b101, 3'b111};

  palindrome_sequence_generator #(.N(5)) dut5 (
    .CLK(clk), .RST(rst), .START(st5), .SEED(sd5),
    .OUT(o5), .VALID(v5), .BUSY(b5), .DONE(d5)
  );

  palindrome_sequence_generator #(.N(7)) dut7 (
    .CLK(clk), .RST(rst), .START(st7), .SEED(sd7),
    .OUT(o7), .VALID(v7), .BUSY(b7), .DONE(d7)
  );

  palindrome_sequence_generator #(.N(3)) dut3 (
    .CLK(clk), .RST(rst), .START(st3), .SEED(sd3),
    .OUT(o3), .VALID(v3), .BUSY(b3), .DONE(d3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={out,valid,busy,done}=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp5(input logic [2:0] s);
    return {s, s[1], s[2]};
  endfunction

  // Checks one N=5 frame already captured; during bits 0..3 drives START=hold with SEED=junk.
  task automatic frame5(input string tag, input logic [4:0] bits, input logic hold,
                        input logic [2:0] junk, input logic chain, input logic [2:0] nseed);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_k%0d", tag, k), {o5, v5, b5, d5}, {bits[4-k], 1'b1, 1'b1, (k == 4)});
      hist = {hist[3:0], o5};
      if (k == 4) begin
        checks++;
        assert (hist === {hist[0], hist[1], hist[2], hist[3], hist[4]}) else begin
          errors++;
          $error("FAIL %s_detector window=%b expected a palindrome", tag, hist);
        end
      end
      if (k == 4) begin
        st5 = chain;
        sd5 = nseed;
      end else begin
        st5 = hold;
        sd5 = junk;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    st5 = 1'b0; st7 = 1'b0; st3 = 1'b0;
    sd5 = '0;   sd7 = '0;   sd3 = '0;
    tick();
    chk("reset5", {o5, v5, b5, d5}, 4'b0000);
    chk("reset7", {o7, v7, b7, d7}, 4'b0000);
    chk("reset3", {o3, v3, b3, d3}, 4'b0000);
    tick();
    rst = 1'b0;
    tick();
    chk("idle5", {o5, v5, b5, d5}, 4'b0000);

    sd5 = 3'b111;
    tick();
    chk("idle_seed_change", {o5, v5, b5, d5}, 4'b0000);

    sd5 = 3'b110; st5 = 1'b1;
    tick();
    frame5("single", 5'b11011, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("single_idle", {o5, v5, b5, d5}, 4'b0000);

    sd5 = 3'b101; st5 = 1'b1;
    tick();
    frame5("b2b_a", 5'b10101, 1'b1, 3'b111, 1'b1, 3'b011);
    frame5("b2b_b", 5'b01110, 1'b1, 3'b000, 1'b0, 3'b000);
    chk("b2b_idle", {o5, v5, b5, d5}, 4'b0000);

    sd5 = 3'b001; st5 = 1'b1;
    tick();
    frame5("ignored", 5'b00100, 1'b1, 3'b111, 1'b0, 3'b000);
    chk("ignored_idle", {o5, v5, b5, d5}, 4'b0000);

    sd5 = 3'b111; st5 = 1'b1;
    tick();
    st5 = 1'b0;
    chk("rstmid_k0", {o5, v5, b5, d5}, 4'b1110);
    tick();
    chk("rstmid_k1", {o5, v5, b5, d5}, 4'b1110);
    tick();
    chk("rstmid_k2", {o5, v5, b5, d5}, 4'b1110);
    #2 rst = 1'b1;
    #1 chk("rstmid_async", {o5, v5, b5, d5}, 4'b0000);
    tick();
    chk("rstmid_held", {o5, v5, b5, d5}, 4'b0000);
    rst = 1'b0;
    tick();
    chk("rstmid_no_resume", {o5, v5, b5, d5}, 4'b0000);
    tick();
    chk("rstmid_no_done", {o5, v5, b5, d5}, 4'b0000);
    sd5 = 3'b010; st5 = 1'b1;
    tick();
    frame5("after_rst", 5'b01010, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("after_rst_idle", {o5, v5, b5, d5}, 4'b0000);

    e7 = 7'b1001001;
    sd7 = 4'b1001; st7 = 1'b1;
    tick();
    st7 = 1'b0;
    sd7 = 4'b0110;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("n7_k%0d", k), {o7, v7, b7, d7}, {e7[6-k], 1'b1, 1'b1, (k == 6)});
      tick();
    end
    chk("n7_idle", {o7, v7, b7, d7}, 4'b0000);

    sd3 = 2'b00; st3 = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("n3_s%0d_k%0d", s, k), {o3, v3, b3, d3},
            {tab3[s][2-k], 1'b1, 1'b1, (k == 2)});
        if (k == 2) begin
          st3 = (s < 3);
          sd3 = 2'(s + 1);
        end else begin
          st3 = 1'b0;
        end
        tick();
      end
    end
    chk("n3_idle", {o3, v3, b3, d3}, 4'b0000);

    cur = 3'($urandom_range(0, 7));
    sd5 = cur; st5 = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      nxt = 3'($urandom_range(0, 7));
      frame5($sformatf("loop%0d", i), exp5(cur), 1'b0, 3'b000, (i < 19), nxt);
      cur = nxt;
    end
    chk("loop_idle", {o5, v5, b5, d5}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/palindrome_sequence_generator.md
PALINDROME_SEQUENCE_GENERATOR -- requirements
Module: palindrome_sequence_generator

Interface
REQ-001 Parameter N SHALL default to 5: serial frame length in bits; legal values are odd and at least 3.
REQ-002 Derived constant H SHALL equal (N+1)/2: seed width in bits.
REQ-003 Port CLK SHALL be an input, 1 bit wide: the single clock, rising-edge active.
REQ-004 Port RST SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-005 Port START SHALL be an input, 1 bit wide: frame request, sampled on the rising edge of CLK.
REQ-006 Port SEED SHALL be an input, H bits wide: the first half of the frame plus its centre bit, sampled together with START.
REQ-007 Port OUT SHALL be an output, 1 bit wide: serial data, one bit per clock.
REQ-008 Port VALID SHALL be an output, 1 bit wide: OUT carries a frame bit this cycle.
REQ-009 Port BUSY SHALL be an output, 1 bit wide: a frame is in progress.
REQ-010 Port DONE SHALL be an output, 1 bit wide: single-cycle pulse during the last bit of a frame.
REQ-011 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-013 In IDLE, a rising edge with START=1 SHALL capture SEED into a seed register S, clear the bit index k to 0, and move the FSM to SEND; the first frame bit appears in the next cycle (latency 1).
REQ-014 In SEND, frame bit k (k = 0..N-1) SHALL be S[H-1-k] for k < H and S[k-H+1] for k >= H; the emitted sequence is therefore a palindrome. Example: N=5, S=3'b110 gives 1,1,0,1,1.
REQ-015 In SEND, VALID and BUSY SHALL both be 1, and k SHALL increment by 1 on every clock.
REQ-016 DONE SHALL be 1 exactly while k = N-1, and 0 at all other times.
REQ-017 When k = N-1 and START=0, the next state SHALL be IDLE, with VALID=0, BUSY=0 and OUT=0.
REQ-018 Back-to-back frames: when k = N-1 and START=1, SEED SHALL be captured, k SHALL wrap to 0, and the FSM SHALL stay in SEND, so the next frame's first bit follows with no gap.
REQ-019 START SHALL be ignored in SEND whenever k != N-1, and S SHALL remain unchanged.
REQ-020 SEED changes outside a capture edge SHALL NOT affect OUT.
REQ-021 In IDLE, OUT SHALL be 0 and VALID, BUSY and DONE SHALL be 0.
REQ-022 The width of k SHALL be clog2(N); k SHALL never exceed N-1.
REQ-023 OUT SHALL be compatible with the team's serial palindrome detector: when CLK is shared and OUT drives the detector's In, the detector's flag SHALL be 1 in the cycle after the fifth bit of any N=5 frame that follows at least 5 valid bits since reset.

Reset
REQ-024 RST=1 SHALL immediately and asynchronously force the FSM to IDLE, S=0, k=0, OUT=0, VALID=0, BUSY=0 and DONE=0.
REQ-025 If RST is asserted mid-frame, the partial frame SHALL be abandoned, with no resumption and no DONE pulse.
REQ-026 After RST deasserts, the first START edge SHALL be handled per REQ-013.

Structure
REQ-027 Shared package palindrome_pkg SHALL hold the state type (IDLE, SEND), the default N, and the function that computes H and the index width.
REQ-028 One sub-module, palindrome_frame_counter, SHALL provide k, a wrap/last flag and load control; FSM, seed register and bit selection SHALL stay in the top module.
REQ-029 The block SHALL contain no latches and no clocks other than CLK.

Verification
REQ-030 Single frame: with N=5, pulse START for one cycle with SEED=3'b110 -> OUT=1,1,0,1,1 on cycles 1-5 after capture; VALID=1 for those 5 cycles; DONE=1 on cycle 5 only; IDLE on cycle 6.
REQ-031 Back-to-back: hold START=1 with SEED=3'b101, then 3'b011 at the k=4 edge -> 10101 then 01110 with no gap, and DONE pulses twice.
REQ-032 Ignored START: with SEED=3'b001, assert START again with SEED=3'b111 at k=2 -> the frame stays 00100 and S is unchanged.
REQ-033 Reset mid-frame: with SEED=3'b111, assert RST asynchronously at k=2 between edges -> all outputs 0 immediately with no DONE; a new START with SEED=3'b010 after release gives 01010.
REQ-034 Parameter sweep: with N=7 and SEED=4'b1001 -> 1,0,0,1,0,0,1 with DONE at k=6; repeat for N=3 with all 4 seeds.
REQ-035 Loopback: drive OUT into the detector with 20 random back-to-back frames -> the detector flag is 1 after every frame end once 5 bits have elapsed since reset.
